// File: rtl/therm2bin_sequencer.sv
// Burst sequencer for the thermometer-to-binary pipeline: issues 2^navg_log sample
// strobes, accumulates the decoded codes LAT cycles later and hands back sum/average.
module therm2bin_sequencer #(
    parameter int B        = 8,
    parameter int LAT      = 7,
    parameter int NMAX_LOG = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [2:0]            i_navg_log,
    output logic                  o_sample,
    input  logic [B-1:0]          i_bin,
    output logic                  o_busy,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic [B+NMAX_LOG-1:0] o_result_sum,
    output logic [B-1:0]          o_result_avg,
    output logic                  o_overrange
);
    localparam int AW  = B + NMAX_LOG;
    localparam int CW  = NMAX_LOG + 1;
    localparam int NLW = (NMAX_LOG < 1) ? 1 : $clog2(NMAX_LOG + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESULT, S_FLUSH} state_t;

    state_t           r_state, w_next;
    logic [LAT-1:0]   r_sr;
    logic [CW-1:0]    r_icnt, r_acnt, r_n;
    logic [NLW-1:0]   r_nlog;
    logic [AW-1:0]    r_acc;
    logic             r_ovr;
    logic [AW-1:0]    r_res_sum;
    logic [B-1:0]     r_res_avg;
    logic             r_res_ovr;

    logic             w_tap, w_sample, w_handshake, w_launch, w_enter_res;
    logic [AW-1:0]    w_acc_nx;
    logic [CW-1:0]    w_acnt_nx;
    logic             w_ovr_nx;
    logic [NLW-1:0]   w_nlog;

    // Tap only counts while a burst owns the pipeline; after a flush it is empty anyway.
    assign w_tap       = r_sr[LAT-1] &&
                         (r_state == S_ISSUE || r_state == S_DRAIN || r_state == S_FLUSH);
    assign w_acc_nx    = r_acc + (w_tap ? AW'(i_bin) : '0);
    assign w_acnt_nx   = r_acnt + CW'(w_tap);
    assign w_ovr_nx    = r_ovr | (w_tap && (&i_bin));
    assign w_sample    = (r_state == S_ISSUE) && !i_abort;
    assign w_handshake = (r_state == S_RESULT) && i_result_ready;
    assign w_launch    = i_start && ((r_state == S_IDLE) || w_handshake);
    assign w_nlog      = (int'(i_navg_log) > NMAX_LOG) ? NLW'(NMAX_LOG) : NLW'(i_navg_log);
    assign w_enter_res = (r_state == S_DRAIN) && (w_next == S_RESULT);

    assign o_sample       = w_sample;
    assign o_busy         = (r_state != S_IDLE);
    assign o_result_valid = (r_state == S_RESULT);
    assign o_result_sum   = r_res_sum;
    assign o_result_avg   = r_res_avg;
    assign o_overrange    = r_res_ovr;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_ISSUE;
            S_ISSUE:  if (i_abort) w_next = S_FLUSH;
                      else if (r_icnt == r_n - CW'(1)) w_next = S_DRAIN;
            S_DRAIN:  if (i_abort) w_next = S_FLUSH;
                      else if (w_acnt_nx == r_n) w_next = S_RESULT;
            S_RESULT: if (w_handshake) w_next = i_start ? S_ISSUE : S_IDLE;
            S_FLUSH:  if (r_sr == '0) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sr      <= '0;
            r_icnt    <= '0;
            r_acnt    <= '0;
            r_n       <= '0;
            r_nlog    <= '0;
            r_acc     <= '0;
            r_ovr     <= 1'b0;
            r_res_sum <= '0;
            r_res_avg <= '0;
            r_res_ovr <= 1'b0;
        end else begin
            r_sr[0] <= w_sample;
            for (int i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
            if (w_launch) begin
                r_nlog <= w_nlog;
                r_n    <= CW'(1) << w_nlog;
                r_icnt <= '0;
                r_acnt <= '0;
                r_acc  <= '0;
                r_ovr  <= 1'b0;
            end else begin
                if (w_sample) r_icnt <= r_icnt + CW'(1);
                r_acc  <= w_acc_nx;
                r_acnt <= w_acnt_nx;
                r_ovr  <= w_ovr_nx;
            end
            // Result registers include the code accumulated in the completing cycle.
            if (w_enter_res) begin
                r_res_sum <= w_acc_nx;
                r_res_avg <= B'(w_acc_nx >> r_nlog);
                r_res_ovr <= w_ovr_nx;
            end
        end
    end
endmodule
